// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 32x32 multiply unit.
package mul_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_NIB = XLEN / NIB_W;

  localparam logic [6:0] OP_MUL   = 7'h30;
  localparam logic [6:0] OP_MULH  = 7'h31;
  localparam logic [6:0] OP_MULHU = 7'h32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

endpackage

// File: rtl/mul_pp_32x4.sv
// Combinational partial product: multiplicand times one multiplier nibble.
module mul_pp_32x4 #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NIB_W = 4
) (
  input  logic [XLEN-1:0]       mcand,
  input  logic [NIB_W-1:0]      nib,
  output logic [XLEN+NIB_W-1:0] pp
);

  assign pp = {{NIB_W{1'b0}}, mcand} * {{XLEN{1'b0}}, nib};

endmodule

// File: rtl/multiply_seq_32.sv
// Iterative 32x32 multiplier, one multiplier nibble per cycle, valid/ready in and out.
// Optional MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier nibbles are zero.
module multiply_seq_32 #(
  parameter int unsigned NIB_W = mul_pkg::NIB_W,
  parameter int unsigned XLEN  = mul_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [XLEN-1:0]   multiplicand,
  input  logic [XLEN-1:0]   multiplier,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   result,
  output logic              out_err
);
  import mul_pkg::*;

  localparam int unsigned LastNib = XLEN / NIB_W - 1;

  state_t              state_q;
  logic [6:0]          op_q;
  logic [XLEN-1:0]     mcand_q, mplier_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   acc_q, acc_sum, acc_fin, product_q;
  logic [2:0]          nib_q;
  logic [XLEN-1:0]     result_q;
  logic                err_q, out_valid_q, in_ready_q;
  logic [XLEN+NIB_W-1:0] pp;
  logic                last_nib, op_ok, is_mulh;
  logic [XLEN-1:0]     a_mag, b_mag;

  // mplier_q is shifted down each cycle, so the current nibble is always its low bits.
  mul_pp_32x4 #(
    .XLEN (XLEN),
    .NIB_W(NIB_W)
  ) u_pp (
    .mcand(mcand_q),
    .nib  (mplier_q[NIB_W-1:0]),
    .pp   (pp)
  );

  always_comb begin
    is_mulh = (opcode == OP_MULH);
    op_ok   = (opcode == OP_MUL) || (opcode == OP_MULH) || (opcode == OP_MULHU);
    a_mag   = (is_mulh && multiplicand[XLEN-1]) ? -multiplicand : multiplicand;
    b_mag   = (is_mulh && multiplier[XLEN-1])   ? -multiplier   : multiplier;
    acc_sum = acc_q + ({{(XLEN-NIB_W){1'b0}}, pp} << (nib_q * NIB_W));
    acc_fin = neg_q ? -acc_sum : acc_sum;
`ifdef MUL_EARLY_OUT_EN
    last_nib = (nib_q == 3'(LastNib)) || ((mplier_q >> NIB_W) == '0);
`else
    last_nib = (nib_q == 3'(LastNib));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      nib_q       <= '0;
      product_q   <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q       <= opcode;
            mcand_q    <= a_mag;
            mplier_q   <= b_mag;
            neg_q      <= is_mulh && (multiplicand[XLEN-1] ^ multiplier[XLEN-1]);
            acc_q      <= '0;
            nib_q      <= '0;
            in_ready_q <= 1'b0;
            err_q      <= !op_ok;
            if (op_ok) begin
              state_q <= StBusy;
            end else begin
              state_q     <= StDone;
              product_q   <= '0;
              result_q    <= '0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StBusy: begin
          acc_q    <= acc_sum;
          nib_q    <= nib_q + 3'd1;
          mplier_q <= mplier_q >> NIB_W;
          if (last_nib) begin
            state_q     <= StDone;
            product_q   <= acc_fin;
            result_q    <= (op_q == OP_MUL) ? acc_fin[XLEN-1:0] : acc_fin[2*XLEN-1:XLEN];
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign result    = result_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_multiply_seq_32.sv
// Self-checking bench for multiply_seq_32: vector table, random vectors, scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_multiply_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  logic [31:0] result;
  logic        out_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  multiply_seq_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .result      (result),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Edges after the acceptance edge until out_valid is seen.
  function automatic int exp_lat(input logic [6:0] op, input logic [31:0] b);
    logic [31:0] m;
    if (op != 7'h30 && op != 7'h31 && op != 7'h32) return 0;
    m = (op == 7'h31 && b[31]) ? -b : b;
`ifdef MUL_EARLY_OUT_EN
    for (int i = 7; i >= 0; i--) if (m[4*i +: 4] != 4'h0) return i + 1;
    return 1;
`else
    return 8 + 0 * int'(m[0]);
`endif
  endfunction

  task automatic model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p, output logic [31:0] r, output logic e);
    e = 1'b0;
    case (op)
      7'h30: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      7'h31: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r = p[63:32];
      end
      7'h32: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      default: begin p = '0; r = '0; e = 1'b1; end
    endcase
  endtask

  task automatic run(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] eprod, input logic [31:0] eres, input logic eerr,
                     input int hold);
    exp_t e;
    int   cnt;
    opcode = op; multiplicand = a; multiplier = b; in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.prod = eprod; e.res = eres; e.err = eerr; e.lat = exp_lat(op, b);
    sb.push_back(e);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      n_total++;
      $display("FAIL timeout: out_valid never rose for op %h a %h b %h", op, a, b);
      return;
    end
    chk("product", product, e.prod);
    chk("result", 64'(result), 64'(e.res));
    chk("out_err", 64'(out_err), 64'(e.err));
    chk("latency", 64'(cnt), 64'(e.lat));
    for (int h = 0; h < hold; h++) begin
      opcode = 7'h30; multiplicand = 32'(h + 9); multiplier = 32'd11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_product", product, e.prod);
      chk("hold_result", 64'(result), 64'(e.res));
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t        tbl[12];
    logic [6:0]  op;
    logic [31:0] a, b, r;
    logic [63:0] p;
    logic        e;

    tbl[0]  = '{7'h32, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE, 1'b0};
    tbl[1]  = '{7'h30, 32'h0000000F, 32'h00000005, 64'h000000000000004B, 32'h0000004B, 1'b0};
    tbl[2]  = '{7'h31, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{7'h31, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000, 1'b0};
    tbl[4]  = '{7'h00, 32'h00000005, 32'h00000007, 64'h0,                32'h0,        1'b1};
    tbl[5]  = '{7'h30, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'h00000001, 1'b0};
    tbl[6]  = '{7'h31, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 32'h00000000, 1'b0};
    tbl[7]  = '{7'h30, 32'h80000000, 32'h00000002, 64'h0000000100000000, 32'h00000000, 1'b0};
    tbl[8]  = '{7'h31, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    tbl[9]  = '{7'h32, 32'h12345678, 32'h00000000, 64'h0,                32'h0,        1'b0};
    tbl[10] = '{7'h32, 32'h10000000, 32'h10000000, 64'h0100000000000000, 32'h01000000, 1'b0};
    tbl[11] = '{7'h7F, 32'h12345678, 32'h9ABCDEF0, 64'h0,                32'h0,        1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].res, tbl[i].err, 0);

    for (int i = 0; i < 8; i++) begin
      op = 7'(7'h30 + $urandom_range(0, 2));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      model(op, a, b, p, r, e);
      run(op, a, b, p, r, e, 0);
    end

    // Backpressure with ignored in_valid pulses while the result is held.
    run(7'h31, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 32'hFFFFFFFF, 1'b0, 5);

    // Reset while nibble 4 is being processed.
    opcode = 7'h30; multiplicand = 32'h00012345; multiplier = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_out_err", 64'(out_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(7'h30, 32'd2, 32'd3, 64'd6, 32'd6, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
